// File: rtl/cpu_pkg.sv
// Shared cpu_core definitions for the Arduino memory bus: state encoding,
// phase-flag encodings ({bus_pc, bus_mar, bus_mdr}) and data widths.
package cpu_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        WR_HI,
        WR_LO,
        RD_HI,
        RD_LO,
        DONE
    } bus_state_t;

    localparam logic [2:0] FL_NONE    = 3'b000;
    localparam logic [2:0] FL_FETCH   = 3'b100;
    localparam logic [2:0] FL_RD_ADDR = 3'b010;
    localparam logic [2:0] FL_WR_ADDR = 3'b011;
    localparam logic [2:0] FL_WR_DATA = 3'b001;

    function automatic logic [2:0] addr_flags(input logic is_fetch, input logic is_wr);
        if (is_fetch)
            return FL_FETCH;
        else if (is_wr)
            return FL_WR_ADDR;
        else
            return FL_RD_ADDR;
    endfunction

endpackage

// File: rtl/mem_bus_if_ard_sync.sv
// ard_sync: STAGES-deep synchronizer for a bundle of async inputs; bit 0 is
// the byte strobe and only its rising edge is exported.
module ard_sync #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-2:0] sync_out,
    output logic             rise
);

    logic [WIDTH-1:0] stage [STAGES];
    logic             prev;

    if (STAGES < 2) begin : g_bad_stages
        $error("ard_sync: STAGES must be at least 2");
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++)
                stage[i] <= '0;
            prev <= 1'b0;
        end else begin
            stage[0] <= async_in;
            for (int unsigned i = 1; i < STAGES; i++)
                stage[i] <= stage[i-1];
            prev <= stage[STAGES-1][0];
        end
    end

    assign sync_out = stage[STAGES-1][WIDTH-1:1];
    assign rise     = stage[STAGES-1][0] & ~prev;

endmodule

// File: rtl/mem_bus_if.sv
// mem_bus_if: serialises 16-bit CPU requests into strobed byte transfers.
// Optional per-byte watchdog enabled by defining BUS_TIMEOUT_EN.
module mem_bus_if
    import cpu_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              fetch,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              done,
    output logic              err,
    input  logic              ard_clk,
    input  logic              ard_data_ready,
    input  logic              ard_receive_ready,
    input  logic [BYTE_W-1:0] in_bus,
    output logic [BYTE_W-1:0] out_bus,
    output logic              bus_pc,
    output logic              bus_mar,
    output logic              bus_mdr
);

    bus_state_t        state;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              fetch_q;
    logic              wr_q;
    logic [BYTE_W-1:0] shadow_hi;
    logic [2:0]        flags;
    logic [1:0]        sync_rdy;
    logic              strobe;
    logic              tx_ok;
    logic              rx_ok;
    logic              busy;
    logic              advance;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("mem_bus_if: TIMEOUT_CYCLES out of range");
    end

    ard_sync #(
        .WIDTH (3),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in({ard_receive_ready, ard_data_ready, ard_clk}),
        .sync_out(sync_rdy),
        .rise    (strobe)
    );

    assign tx_ok = strobe & sync_rdy[1];
    assign rx_ok = strobe & sync_rdy[0];
    assign {bus_pc, bus_mar, bus_mdr} = flags;

    always_comb begin
        busy    = 1'b0;
        advance = 1'b0;
        unique case (state)
            IDLE:                         advance = req;
            ADDR_HI, ADDR_LO, WR_HI, WR_LO: begin
                busy    = 1'b1;
                advance = tx_ok;
            end
            RD_HI, RD_LO: begin
                busy    = 1'b1;
                advance = rx_ok;
            end
            DONE:                         advance = 1'b1;
            default:                      advance = 1'b0;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    logic [15:0] cnt;
    logic        timeout;

    // A byte accepted on the limit cycle wins over the abort.
    assign timeout = busy && !advance && (cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_bus   <= '0;
            flags     <= FL_NONE;
            done      <= 1'b0;
            rdata     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            fetch_q   <= 1'b0;
            wr_q      <= 1'b0;
            shadow_hi <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt       <= '0;
            err       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            err  <= 1'b0;
            cnt  <= (advance || !busy) ? '0 : cnt + 16'd1;
`endif
            unique case (state)
                IDLE: begin
                    out_bus <= '0;
                    flags   <= FL_NONE;
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        fetch_q <= fetch;
                        wr_q    <= we & ~fetch;
                        out_bus <= addr[15:8];
                        flags   <= addr_flags(fetch, we & ~fetch);
                        state   <= ADDR_HI;
                    end
                end
                ADDR_HI: if (tx_ok) begin
                    out_bus <= addr_q[7:0];
                    state   <= ADDR_LO;
                end
                ADDR_LO: if (tx_ok) begin
                    if (wr_q) begin
                        out_bus <= wdata_q[15:8];
                        flags   <= FL_WR_DATA;
                        state   <= WR_HI;
                    end else begin
                        out_bus <= '0;
                        flags   <= FL_NONE;
                        state   <= RD_HI;
                    end
                end
                WR_HI: if (tx_ok) begin
                    out_bus <= wdata_q[7:0];
                    state   <= WR_LO;
                end
                WR_LO: if (tx_ok) begin
                    out_bus <= '0;
                    flags   <= FL_NONE;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                RD_HI: if (rx_ok) begin
                    shadow_hi <= in_bus;
                    state     <= RD_LO;
                end
                RD_LO: if (rx_ok) begin
                    rdata <= {shadow_hi, in_bus};
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
`ifdef BUS_TIMEOUT_EN
            if (timeout) begin
                out_bus <= '0;
                flags   <= FL_NONE;
                err     <= 1'b1;
                state   <= IDLE;
            end
`endif
        end
    end

endmodule

// File: doc/mem_bus_if.md
Name: mem_bus_if

Overview:
- Memory bus interface unit inside cpu_core. Converts 16-bit CPU memory requests (instruction fetch, data read, data write) into the byte-serial, strobe-handshaked transfers used by the external Arduino memory emulator.
- Drives out_bus and the bus_pc/bus_mar/bus_mdr phase flags, and captures in_bus.
- Sits directly between the cpu_core control FSM and the chip pins.

Parameters:
- SYNC_STAGES, 2: flop stages on each asynchronous Arduino input (ard_clk, ard_data_ready, ard_receive_ready); minimum 2.
- TIMEOUT_CYCLES, 4096: per-byte watchdog limit. Used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  1  CPU request; sampled only in IDLE.
- fetch  in  1  request is an instruction fetch (read from PC).
- we  in  1  write request (ignored when fetch=1).
- addr  in  16  byte address.
- wdata  in  16  write data.
- rdata  out  16  read data; valid when done=1, held until the next read completes.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle abort pulse (BUS_TIMEOUT_EN only, else tied 0).
- ard_clk  in  1  Arduino byte strobe; asynchronous.
- ard_data_ready  in  1  Arduino is driving a valid byte on in_bus; asynchronous.
- ard_receive_ready  in  1  Arduino can accept a byte; asynchronous.
- in_bus  in  8  byte from Arduino.
- out_bus  out  8  byte to Arduino.
- bus_pc  out  1  address phase of a fetch.
- bus_mar  out  1  address phase of a data access.
- bus_mdr  out  1  write transaction marker.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n); all state is updated only on the rising edge of clk.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; out_bus=0; all flags 0; done=0; err=0; rdata=0; synchronizers cleared.
  - Reset mid-transaction abandons it immediately, with no done pulse.
- Input synchronization and edge detection:
  - Each asynchronous input passes through SYNC_STAGES flops.
  - A byte strobe is a synchronized ard_clk 0->1 edge (one extra flop for edge detection).
  - in_bus is sampled raw on the strobe cycle. The Arduino holds it stable while ard_data_ready is high.
- States: IDLE, ADDR_HI, ADDR_LO, WR_HI, WR_LO, RD_HI, RD_LO, DONE.
- IDLE: outputs 0. When req=1, latch addr, wdata, fetch and we, then go to ADDR_HI.
- Flag encoding (held for the whole phase):
  - Fetch address phase: bus_pc=1.
  - Data read address phase: bus_mar=1.
  - Data write address phase: bus_mar=1 and bus_mdr=1.
  - Write data phase: bus_mdr=1 only.
  - Read data phase: all flags 0.
- Transmit byte (ADDR_*, WR_*):
  - out_bus is registered from the latched value on state entry.
  - Advance on a strobe while synchronized ard_receive_ready=1.
  - A strobe while ard_receive_ready=0 is ignored.
- Receive byte (RD_*): on a strobe while synchronized ard_data_ready=1, capture in_bus into the high or low half of a shadow register, then advance.
- Sequencing (high byte always first):
  - ADDR_HI -> ADDR_LO.
  - ADDR_LO -> WR_HI if write, else RD_HI.
  - WR_HI -> WR_LO -> DONE.
  - RD_HI -> RD_LO -> DONE.
- DONE: for one cycle done=1 and rdata updates from the shadow register (reads only). Then return to IDLE.
- Request handling:
  - req is ignored outside IDLE.
  - A new req may be taken on the cycle after DONE.
- Minimum latency from req to done: 3 + SYNC_STAGES cycles per byte-strobe path, bounded by the Arduino strobe rate. Each byte consumes exactly one strobe.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on every state entry and increments in ADDR_*, WR_* and RD_*.
  - When it reaches TIMEOUT_CYCLES-1: err pulses for one cycle, flags and out_bus go to 0, state goes to IDLE, no done pulse, rdata unchanged.
- When undefined: no counter is built, err is constant 0, and the FSM waits indefinitely.

Decomposition:
- Shared package (cpu_pkg): bus_state_t enum; flag-encoding constants; BYTE_W=8 and WORD_W=16.
- One sub-module, ard_sync: a parameterized multi-bit synchronizer with a rising-edge output for ard_clk. It is instantiated once for the three control inputs.

Test Plan:
- Fetch, addr=0x1234, Arduino returns 0xBE then 0xEF:
  - out_bus 0x12 then 0x34, with bus_pc=1 and mar=mdr=0.
  - One done pulse with rdata=0xBEEF.
- Write, addr=0x00A0, wdata=0xCAFE:
  - Bytes 0xA0-hi(0x00), 0xA0, 0xCA, 0xFE.
  - bus_mar=bus_mdr=1 for the address bytes; bus_mdr only for the data bytes.
  - done after the 4th strobe; rdata unchanged.
- Data read with strobes issued while ard_receive_ready=0: strobes are ignored, and the byte is accepted only on the first strobe with ready=1.
- req held high through a transaction: exactly one transaction per req rise. A second transaction starts only after the DONE->IDLE cycle.
- rst_n low during RD_LO: next cycle IDLE, all outputs 0, no done; a subsequent fetch of 0x0001 completes normally.
- With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=16: no strobes after ADDR_HI -> err pulses on cycle 16, returns to IDLE, done never asserted.
